// File: rtl/execute_pipe.sv
// Execute stage for RV32I-style instructions. Decode supplies the
// instruction class and operands. Results are registered behind a
// valid/ready output handshake. With SERIAL_SHIFT=1, shift instructions
// take one cycle per shifted bit in a dedicated SHIFT state.
module execute_pipe #(
  parameter int XLEN         = 32,
  parameter int SERIAL_SHIFT = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [2:0]      op_class,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            write_enable,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_value,
  output logic            next_pc_valid,
  output logic [XLEN-1:0] next_pc
);

  localparam int SW = $clog2(XLEN);
  localparam logic SERIAL = (SERIAL_SHIFT != 0);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [2:0] CLS_BRANCH = 3'd0;
  localparam logic [2:0] CLS_JALR   = 3'd1;
  localparam logic [2:0] CLS_JAL    = 3'd2;
  localparam logic [2:0] CLS_LUI    = 3'd3;
  localparam logic [2:0] CLS_AUIPC  = 3'd4;
  localparam logic [2:0] CLS_REGIMM = 3'd5;
  localparam logic [2:0] CLS_REGREG = 3'd6;

  logic [0:0] state;

  // Instruction fields and sign-extended immediates.
  logic [2:0]      funct3;
  logic            alt;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] jalr_sum;
  logic            unused_opcode;

  assign funct3        = instruction[14:12];
  assign alt           = instruction[30];
  assign rd_idx        = instruction[11:7];
  assign imm_i         = XLEN'($signed(instruction[31:20]));
  assign imm_u         = XLEN'($signed({instruction[31:12], 12'b0}));
  assign imm_b         = XLEN'($signed({instruction[31], instruction[7],
                                        instruction[30:25], instruction[11:8], 1'b0}));
  assign imm_j         = XLEN'($signed({instruction[31], instruction[19:12],
                                        instruction[20], instruction[30:21], 1'b0}));
  assign alu_b         = (op_class == CLS_REGREG) ? rs2_value : imm_i;
  assign jalr_sum      = rs1_value + imm_i;
  assign unused_opcode = &{1'b0, instruction[6:0]};

  // Single-cycle result for the accepted instruction.
  logic            res_we;
  logic [XLEN-1:0] res_value;
  logic            res_npv;
  logic [XLEN-1:0] res_np;
  logic            is_shift;
  logic            shift_left;
  logic            shift_arith;
  logic            taken;
  logic [SW-1:0]   shamt;

  // Decode the class/funct3 and compute result, redirect and shift controls.
  always_comb begin
    res_we      = 1'b0;
    res_value   = '0;
    res_npv     = 1'b0;
    res_np      = '0;
    is_shift    = 1'b0;
    shift_left  = 1'b0;
    shift_arith = 1'b0;
    taken       = 1'b0;
    shamt       = alu_b[SW-1:0];
    case (op_class)
      CLS_BRANCH: begin
        case (funct3)
          3'd0:    taken = (rs1_value == rs2_value);
          3'd1:    taken = (rs1_value != rs2_value);
          3'd4:    taken = ($signed(rs1_value) <  $signed(rs2_value));
          3'd5:    taken = ($signed(rs1_value) >= $signed(rs2_value));
          3'd6:    taken = (rs1_value <  rs2_value);
          3'd7:    taken = (rs1_value >= rs2_value);
          default: taken = 1'b0;
        endcase
        res_npv = taken;
        res_np  = taken ? (pc + imm_b) : '0;
      end
      CLS_JALR: begin
        res_we    = 1'b1;
        res_value = pc + FOUR;
        res_npv   = 1'b1;
        res_np    = {jalr_sum[XLEN-1:1], 1'b0};
      end
      CLS_JAL: begin
        res_we    = 1'b1;
        res_value = pc + FOUR;
        res_npv   = 1'b1;
        res_np    = pc + imm_j;
      end
      CLS_LUI: begin
        res_we    = 1'b1;
        res_value = imm_u;
      end
      CLS_AUIPC: begin
        res_we    = 1'b1;
        res_value = pc + imm_u;
      end
      CLS_REGIMM, CLS_REGREG: begin
        res_we = 1'b1;
        case (funct3)
          3'd0: res_value = (op_class == CLS_REGREG && alt) ? (rs1_value - alu_b)
                                                           : (rs1_value + alu_b);
          3'd1: begin
            is_shift   = 1'b1;
            shift_left = 1'b1;
          end
          3'd2: res_value = {{(XLEN-1){1'b0}}, ($signed(rs1_value) < $signed(alu_b))};
          3'd3: res_value = {{(XLEN-1){1'b0}}, (rs1_value < alu_b)};
          3'd4: res_value = rs1_value ^ alu_b;
          3'd5: begin
            is_shift    = 1'b1;
            shift_arith = alt;
          end
          3'd6: res_value = rs1_value | alu_b;
          default: res_value = rs1_value & alu_b;
        endcase
        if (is_shift) begin
          if (shift_left)
            res_value = rs1_value << shamt;
          else if (shift_arith)
            res_value = $unsigned($signed(rs1_value) >>> shamt);
          else
            res_value = rs1_value >> shamt;
        end
      end
      default: begin
        res_we = 1'b0;
      end
    endcase
    if (rd_idx == 5'd0)
      res_we = 1'b0;
  end

  // Iterative shifter state.
  logic [XLEN-1:0] sh_val;
  logic [XLEN-1:0] sh_next;
  logic [SW-1:0]   sh_cnt;
  logic            sh_left;
  logic            sh_arith;
  logic [4:0]      sh_rd;
  logic            sh_we;

  logic accept;
  logic start_serial;
  logic load_direct;
  logic shift_done;

  assign in_ready     = !reset && (state == IDLE) && (!out_valid || out_ready);
  assign accept       = in_valid && in_ready;
  assign start_serial = SERIAL && accept && is_shift && (shamt != '0);
  assign load_direct  = accept && !start_serial;
  assign shift_done   = (state == SHIFT) && (sh_cnt == SW'(1));

  // One-bit step of the iterative shifter.
  always_comb begin
    sh_next = sh_val;
    if (sh_left)
      sh_next = {sh_val[XLEN-2:0], 1'b0};
    else
      sh_next = {(sh_arith & sh_val[XLEN-1]), sh_val[XLEN-1:1]};
  end

  // FSM and shifter: a serial shift parks here until the count runs out.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      sh_val   <= '0;
      sh_cnt   <= '0;
      sh_left  <= 1'b0;
      sh_arith <= 1'b0;
      sh_rd    <= '0;
      sh_we    <= 1'b0;
    end else if (start_serial) begin
      state    <= SHIFT;
      sh_val   <= rs1_value;
      sh_cnt   <= shamt;
      sh_left  <= shift_left;
      sh_arith <= shift_arith;
      sh_rd    <= rd_idx;
      sh_we    <= res_we;
    end else if (state == SHIFT) begin
      sh_val <= sh_next;
      sh_cnt <= sh_cnt - SW'(1);
      if (sh_cnt == SW'(1))
        state <= IDLE;
    end
  end

  // Output registers: load on completion, hold until consumed, then drop valids.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid     <= 1'b0;
      write_enable  <= 1'b0;
      rd            <= '0;
      rd_value      <= '0;
      next_pc_valid <= 1'b0;
      next_pc       <= '0;
    end else if (load_direct) begin
      out_valid     <= 1'b1;
      write_enable  <= res_we;
      rd            <= rd_idx;
      rd_value      <= res_value;
      next_pc_valid <= res_npv;
      next_pc       <= res_np;
    end else if (shift_done) begin
      // The last step is written straight to the output, so shamt steps
      // finish with the result valid shamt+1 cycles after acceptance.
      out_valid     <= 1'b1;
      write_enable  <= sh_we;
      rd            <= sh_rd;
      rd_value      <= sh_next;
      next_pc_valid <= 1'b0;
      next_pc       <= '0;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
      write_enable  <= 1'b0;
      next_pc_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Scoreboard bench: one barrel-shift and one serial-shift instance, with
// directed cases followed by randomized traffic against a reference model.
module tb_execute_pipe;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        iv [2];
  logic        ir [2];
  logic [31:0] ins[2];
  logic [2:0]  cls[2];
  logic [31:0] pcv[2];
  logic [31:0] r1 [2];
  logic [31:0] r2 [2];
  logic        ov [2];
  logic        ordy[2];
  logic        we [2];
  logic [4:0]  rdo[2];
  logic [31:0] rdv[2];
  logic        npv[2];
  logic [31:0] npc[2];

  execute_pipe #(.XLEN(32), .SERIAL_SHIFT(0)) u_bar (
    .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
    .instruction(ins[0]), .op_class(cls[0]), .pc(pcv[0]),
    .rs1_value(r1[0]), .rs2_value(r2[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .write_enable(we[0]), .rd(rdo[0]), .rd_value(rdv[0]),
    .next_pc_valid(npv[0]), .next_pc(npc[0]));

  execute_pipe #(.XLEN(32), .SERIAL_SHIFT(1)) u_ser (
    .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .instruction(ins[1]), .op_class(cls[1]), .pc(pcv[1]),
    .rs1_value(r1[1]), .rs2_value(r2[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .write_enable(we[1]), .rd(rdo[1]), .rd_value(rdv[1]),
    .next_pc_valid(npv[1]), .next_pc(npc[1]));

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic        chk_val;
    logic [31:0] val;
    logic        npv;
    logic [31:0] np;
    int unsigned lat;
    int unsigned sh;
    int unsigned due;
  } exp_t;

  exp_t        q[2][$];
  int unsigned busy_lo[2];
  int unsigned busy_hi[2];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        rnd_rdy = 1'b0;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference ALU: shifts as multiply/divide by powers of two.
  function automatic logic [31:0] alu(input logic [2:0] f, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p2, t;
    p2 = 64'd1 << b[4:0];
    case (f)
      3'd0: return alt ? (a - b) : (a + b);
      3'd1: begin t = {32'b0, a} * p2; return t[31:0]; end
      3'd2: return {31'b0, ($signed(a) < $signed(b))};
      3'd3: return {31'b0, (a < b)};
      3'd4: return a ^ b;
      3'd5: begin
        if (alt && a[31]) begin t = {32'b0, ~a} / p2; return ~t[31:0]; end
        t = {32'b0, a} / p2;
        return t[31:0];
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] i, input logic [2:0] c,
                                 input logic [31:0] p, input logic [31:0] a,
                                 input logic [31:0] b, input logic serial);
    exp_t e;
    logic signed [31:0] si;
    logic [31:0] immi, immu, immb, immj, opb;
    logic [12:0] bf;
    logic [20:0] jf;
    logic [2:0]  f;
    logic        tk;
    si   = i;
    immi = si >>> 20;
    immu = i & 32'hFFFF_F000;
    bf   = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    jf   = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    immb = {{19{bf[12]}}, bf};
    immj = {{11{jf[20]}}, jf};
    f    = i[14:12];
    e.rd = i[11:7]; e.we = 1'b0; e.chk_val = 1'b1; e.val = '0;
    e.npv = 1'b0; e.np = '0; e.lat = 1; e.sh = 0; e.due = 0;
    case (c)
      3'd0: begin
        case (f)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        e.chk_val = 1'b0; e.npv = tk; e.np = p + immb;
      end
      3'd1: begin e.we = 1'b1; e.val = p + 4; e.npv = 1'b1; e.np = (a + immi) & 32'hFFFF_FFFE; end
      3'd2: begin e.we = 1'b1; e.val = p + 4; e.npv = 1'b1; e.np = p + immj; end
      3'd3: begin e.we = 1'b1; e.val = immu; end
      3'd4: begin e.we = 1'b1; e.val = p + immu; end
      3'd5, 3'd6: begin
        opb  = (c == 3'd6) ? b : immi;
        e.we = 1'b1;
        e.val = alu(f, (f == 3'd5 || (c == 3'd6 && f == 3'd0)) ? i[30] : 1'b0, a, opb);
        if (serial && (f == 3'd1 || f == 3'd5)) begin
          e.sh  = opb[4:0];
          e.lat = e.sh + 1;
        end
      end
      default: e.chk_val = 1'b0;
    endcase
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  // Present one instruction and wait (bounded) for it to be accepted.
  task automatic issue(input int d, input logic [31:0] i, input logic [2:0] c,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   k;
    logic ok;
    ins[d] = i; cls[d] = c; pcv[d] = p; r1[d] = a; r2[d] = b; iv[d] = 1'b1;
    k = 0; ok = 1'b1;
    @(negedge clock);
    while (ir[d] !== 1'b1) begin
      k++;
      if (k > 300) begin
        n_cmp++; n_bad++; ok = 1'b0;
        $display("FAIL dut%0d accept_timeout: in_ready never 1 (cycle %0d)", d, cyc);
        break;
      end
      @(negedge clock);
    end
    if (ok) begin
      e = model(i, c, p, a, b, d == 1);
      e.due = cyc + e.lat;
      if (e.sh > 0) begin busy_lo[d] = cyc + 1; busy_hi[d] = cyc + 1 + e.sh; end
      q[d].push_back(e);
    end
    @(posedge clock); #1;
    iv[d] = 1'b0;
  endtask

  task automatic rand_run(input int d, input int n);
    logic [31:0] i, a, b, p;
    logic [2:0]  c;
    for (int k = 0; k < n; k++) begin
      i = $urandom;
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 2) == 0) a = a & 32'h8000_00FF;
      p = $urandom & 32'hFFFF_FFFC;
      issue(d, i, c, p, a, b);
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
  endtask

  // Monitors: pop on each new result, check hold stability and busy in_ready.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic        presented = 1'b0;
    logic [95:0] snap;
    exp_t        cur;
    exp_t        drop;
    always @(negedge clock) begin
      if (reset) begin
        presented = 1'b0;
        q[g].delete();
        busy_lo[g] = 0;
        busy_hi[g] = 0;
      end else begin
        if (ov[g]) begin
          if (!presented) begin
            if (q[g].size() == 0) begin
              check($sformatf("dut%0d spurious_out_valid", g), 96'(ov[g]), 96'(0));
            end else begin
              cur = q[g].pop_front();
              check($sformatf("dut%0d latency", g), 96'(cyc), 96'(cur.due));
              check($sformatf("dut%0d rd", g), 96'(rdo[g]), 96'(cur.rd));
              check($sformatf("dut%0d write_enable", g), 96'(we[g]), 96'(cur.we));
              check($sformatf("dut%0d next_pc_valid", g), 96'(npv[g]), 96'(cur.npv));
              if (cur.chk_val) check($sformatf("dut%0d rd_value", g), 96'(rdv[g]), 96'(cur.val));
              if (cur.npv) check($sformatf("dut%0d next_pc", g), 96'(npc[g]), 96'(cur.np));
              presented = 1'b1;
            end
            snap = {we[g], rdo[g], rdv[g], npv[g], npc[g]};
          end else begin
            check($sformatf("dut%0d hold_stable", g),
                  96'({we[g], rdo[g], rdv[g], npv[g], npc[g]}), snap);
          end
          if (ordy[g]) presented = 1'b0;
        end else begin
          check($sformatf("dut%0d idle_next_pc_valid", g), 96'(npv[g]), 96'(0));
          if (q[g].size() > 0 && cyc >= q[g][0].due) begin
            check($sformatf("dut%0d out_valid_missing", g), 96'(ov[g]), 96'(1));
            drop = q[g].pop_front();
          end
        end
        if (cyc >= busy_lo[g] && cyc < busy_hi[g])
          check($sformatf("dut%0d in_ready_during_shift", g), 96'(ir[g]), 96'(0));
      end
    end
  end

  initial forever begin
    @(posedge clock); #1;
    if (rnd_rdy) begin
      ordy[0] = ($urandom_range(0, 3) != 0);
      ordy[1] = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int k;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ins[d] = '0; cls[d] = '0; pcv[d] = '0; r1[d] = '0; r2[d] = '0; ordy[d] = 1'b1;
    end
    repeat (2) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset_out", d),
            96'({ov[d], we[d], npv[d], rdo[d], rdv[d], npc[d]}), 96'(0));
      check($sformatf("dut%0d reset_in_ready", d), 96'(ir[d]), 96'(0));
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("dut0 in_ready_after_reset", 96'(ir[0]), 96'(1));
    check("dut1 in_ready_after_reset", 96'(ir[1]), 96'(1));
    @(posedge clock); #1;

    // ADDI x5,x0,-1
    issue(0, 32'hFFF0_0293, 3'd5, 32'h0, 32'h0, 32'h0);
    // BEQ +16 taken, then not taken
    issue(0, {7'b0, 5'd2, 5'd1, 3'b000, 5'b10000, 7'b1100011}, 3'd0, 32'h100, 32'd7, 32'd7);
    issue(0, {7'b0, 5'd2, 5'd1, 3'b000, 5'b10000, 7'b1100011}, 3'd0, 32'h100, 32'd7, 32'd8);
    // JALR x1, 0(rs1=0x203)
    issue(0, {12'd0, 5'd3, 3'b000, 5'd1, 7'b1100111}, 3'd1, 32'h400, 32'h203, 32'h0);
    // serial SRA by 4
    issue(1, {7'b0100000, 5'd2, 5'd1, 3'b101, 5'd3, 7'b0110011}, 3'd6, 32'h0, 32'h8000_0000, 32'd4);
    // invalid class and shamt=0 on the serial unit
    issue(1, 32'h1234_5678, 3'd7, 32'h0, 32'h5, 32'h6);
    issue(1, {7'b0, 5'd2, 5'd1, 3'b001, 5'd9, 7'b0110011}, 3'd6, 32'h0, 32'hABCD_0001, 32'h20);

    // Back-pressure for 3 cycles, then back-to-back.
    ordy[0] = 1'b0;
    issue(0, {12'd5, 5'd0, 3'b000, 5'd6, 7'b0010011}, 3'd5, 32'h0, 32'h0, 32'h0);
    repeat (3) begin
      @(negedge clock);
      check("dut0 in_ready_held", 96'(ir[0]), 96'(0));
    end
    @(posedge clock); #1;
    ordy[0] = 1'b1;
    issue(0, {12'd9, 5'd0, 3'b000, 5'd7, 7'b0010011}, 3'd5, 32'h0, 32'h0, 32'h0);

    // Reset in the second cycle of a 10-bit serial shift.
    repeat (3) begin @(posedge clock); #1; end
    issue(1, {7'b0, 5'd2, 5'd1, 3'b101, 5'd4, 7'b0110011}, 3'd6, 32'h0, 32'hFFFF_0000, 32'd10);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("dut1 in_ready_in_reset", 96'(ir[1]), 96'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("dut1 out_valid_after_reset", 96'(ov[1]), 96'(0));
    check("dut1 in_ready_after_release", 96'(ir[1]), 96'(1));
    repeat (15) @(negedge clock);
    @(posedge clock); #1;

    rnd_rdy = 1'b1;
    fork
      rand_run(0, 150);
      rand_run(1, 120);
    join

    k = 0;
    while ((q[0].size() > 0 || q[1].size() > 0) && k < 500) begin
      @(negedge clock);
      k++;
    end
    if (q[0].size() > 0 || q[1].size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding", q[0].size(), q[1].size());
    end
    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
